// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and width helper for the generalised pipeline stage register.
package pipe_pkg;

  localparam int STALL_HOLD   = 0;
  localparam int STALL_BUBBLE = 1;

  // Total bit width of the packed field bus.
  function automatic int packed_w(input int num_ch, input int data_w);
    return num_ch * data_w;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Count up on inc, stick at all-ones instead of wrapping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register: valid/ready handshake, optional skid
// entry, hold/bubble stall modes, synchronous flush and saturating counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 4,
  parameter int STALL_MODE = STALL_HOLD,
  parameter int SKID       = 1,
  parameter int CNT_W      = 16
) (
  input  logic                                   Clk,
  input  logic                                   Reset,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [packed_w(NUM_CH, DATA_W)-1:0]    in_data,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [packed_w(NUM_CH, DATA_W)-1:0]    out_data,
  input  logic                                   stall,
  input  logic                                   Clr,
  output logic [CNT_W-1:0]                       stall_cnt,
  output logic [CNT_W-1:0]                       flush_cnt
);

  localparam int PW        = packed_w(NUM_CH, DATA_W);
  localparam bit HOLD_MODE = (STALL_MODE == STALL_HOLD);

  logic          main_valid_r, skid_valid_r;
  logic [PW-1:0] main_data_r,  skid_data_r;
  logic          main_valid_s, skid_valid_s;
  logic [PW-1:0] main_data_s,  skid_data_s;
  logic          in_ready_s, out_valid_s, freeze_s;
  logic          in_xfer_s, out_xfer_s;

  assign freeze_s = stall && HOLD_MODE;

  // Handshake qualifiers; with a skid entry in_ready depends only on state.
  always_comb begin
    out_valid_s = main_valid_r && !Clr && !freeze_s && !Reset;
    if (SKID != 0) begin
      in_ready_s = !skid_valid_r && !stall && !Clr && !Reset;
    end else begin
      in_ready_s = !stall && !Clr && !Reset && (!main_valid_r || out_ready);
    end
  end

  assign in_xfer_s  = in_valid && in_ready_s;
  assign out_xfer_s = out_valid_s && out_ready;

  // Next-state for main and skid entries; departing entries leave data zero.
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    if (Clr) begin
      main_valid_s = 1'b0;
      main_data_s  = {PW{1'b0}};
      skid_valid_s = 1'b0;
      skid_data_s  = {PW{1'b0}};
    end else if (freeze_s) begin
      main_valid_s = main_valid_r;
    end else if (out_xfer_s) begin
      if (skid_valid_r) begin
        main_valid_s = 1'b1;
        main_data_s  = skid_data_r;
        skid_valid_s = 1'b0;
        skid_data_s  = {PW{1'b0}};
      end else if (in_xfer_s) begin
        main_valid_s = 1'b1;
        main_data_s  = in_data;
      end else begin
        main_valid_s = 1'b0;
        main_data_s  = {PW{1'b0}};
      end
    end else if (!main_valid_r) begin
      if (in_xfer_s) begin
        main_valid_s = 1'b1;
        main_data_s  = in_data;
      end else begin
        main_valid_s = 1'b0;
      end
    end else if (in_xfer_s && (SKID != 0)) begin
      skid_valid_s = 1'b1;
      skid_data_s  = in_data;
    end else begin
      skid_valid_s = skid_valid_r;
    end
  end

  // Entry registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      main_valid_r <= 1'b0;
      main_data_r  <= {PW{1'b0}};
      skid_valid_r <= 1'b0;
      skid_data_r  <= {PW{1'b0}};
    end else begin
      main_valid_r <= main_valid_s;
      main_data_r  <= main_data_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_s;
  assign out_data  = main_data_r;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (stall && !Clr),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .Clk   (Clk),
    .Reset (Reset),
    .inc   (Clr),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: table-driven vectors on a HOLD/skid stage, plus hand
// sequences on a BUBBLE stage with 2-bit counters and a single-entry stage.
module tb_pipe_stage_reg;

  logic         Clk;
  logic         rst      [3];
  logic         iv       [3];
  logic         ir       [3];
  logic [127:0] idata    [3];
  logic         ov       [3];
  logic         ordy     [3];
  logic [127:0] odata    [3];
  logic         st       [3];
  logic         clr      [3];
  logic [15:0]  sc0, fc0, sc2, fc2;
  logic [1:0]   sc1, fc1;

  int n_chk  = 0;
  int n_fail = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  pipe_stage_reg #(.STALL_MODE(0), .SKID(1), .CNT_W(16)) dut0 (
    .Clk(Clk), .Reset(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idata[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(odata[0]), .stall(st[0]),
    .Clr(clr[0]), .stall_cnt(sc0), .flush_cnt(fc0));

  pipe_stage_reg #(.STALL_MODE(1), .SKID(1), .CNT_W(2)) dut1 (
    .Clk(Clk), .Reset(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idata[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(odata[1]), .stall(st[1]),
    .Clr(clr[1]), .stall_cnt(sc1), .flush_cnt(fc1));

  pipe_stage_reg #(.STALL_MODE(0), .SKID(0), .CNT_W(16)) dut2 (
    .Clk(Clk), .Reset(rst[2]), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idata[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(odata[2]), .stall(st[2]),
    .Clr(clr[2]), .stall_cnt(sc2), .flush_cnt(fc2));

  // Distinct word per channel so packing mistakes show up; empty reads as 0.
  function automatic logic [127:0] mk(input logic [31:0] v);
    if (v == 32'd0) return 128'd0;
    return {v + 32'd3, v + 32'd2, v + 32'd1, v};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int k, input int r, input int v, input logic [31:0] d,
                       input int o, input int s, input int c);
    rst[k]   = (r != 0);
    iv[k]    = (v != 0);
    idata[k] = mk(d);
    ordy[k]  = (o != 0);
    st[k]    = (s != 0);
    clr[k]   = (c != 0);
  endtask

  task automatic to_neg();
    @(negedge Clk);
  endtask

  task automatic to_next();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_port(input int k, input string tag, input int e_ir, input int e_ov,
                          input logic [31:0] e_od);
    chk({tag, " in_ready"},  {127'd0, ir[k]}, 128'(e_ir));
    chk({tag, " out_valid"}, {127'd0, ov[k]}, 128'(e_ov));
    chk({tag, " out_data"},  odata[k], mk(e_od));
  endtask

  typedef struct {
    int          r, v;
    logic [31:0] d;
    int          o, s, c, e_ir, e_ov;
    logic [31:0] e_od;
    int          e_sc, e_fc;
  } vec_t;

  function automatic vec_t mv(int r, int v, logic [31:0] d, int o, int s, int c,
                              int e_ir, int e_ov, logic [31:0] e_od, int e_sc, int e_fc);
    vec_t t;
    t.r = r; t.v = v; t.d = d; t.o = o; t.s = s; t.c = c;
    t.e_ir = e_ir; t.e_ov = e_ov; t.e_od = e_od; t.e_sc = e_sc; t.e_fc = e_fc;
    return t;
  endfunction

  vec_t tbl[26];

  initial begin
    //            rst iv data        ordy st clr | ir ov out_data   sc fc
    tbl[0]  = mv(1, 1, 32'h99, 1, 0, 0,  0, 0, 32'h0,  0, 0);
    tbl[1]  = mv(0, 1, 32'h11, 1, 0, 0,  1, 0, 32'h0,  0, 0);
    tbl[2]  = mv(0, 1, 32'h22, 1, 0, 0,  1, 1, 32'h11, 0, 0);
    tbl[3]  = mv(0, 1, 32'h33, 1, 0, 0,  1, 1, 32'h22, 0, 0);
    tbl[4]  = mv(0, 0, 32'h0,  1, 0, 0,  1, 1, 32'h33, 0, 0);
    tbl[5]  = mv(0, 0, 32'h0,  1, 0, 0,  1, 0, 32'h0,  0, 0);
    tbl[6]  = mv(0, 1, 32'hA0, 0, 0, 0,  1, 0, 32'h0,  0, 0);
    tbl[7]  = mv(0, 1, 32'hA1, 0, 0, 0,  1, 1, 32'hA0, 0, 0);
    tbl[8]  = mv(0, 1, 32'hA2, 0, 0, 0,  0, 1, 32'hA0, 0, 0);
    tbl[9]  = mv(0, 0, 32'h0,  1, 0, 0,  0, 1, 32'hA0, 0, 0);
    tbl[10] = mv(0, 0, 32'h0,  1, 0, 0,  1, 1, 32'hA1, 0, 0);
    tbl[11] = mv(0, 0, 32'h0,  1, 0, 0,  1, 0, 32'h0,  0, 0);
    tbl[12] = mv(0, 1, 32'h55, 0, 0, 0,  1, 0, 32'h0,  0, 0);
    tbl[13] = mv(0, 0, 32'h0,  0, 1, 0,  0, 0, 32'h55, 0, 0);
    tbl[14] = mv(0, 1, 32'h66, 1, 1, 0,  0, 0, 32'h55, 1, 0);
    tbl[15] = mv(0, 0, 32'h0,  1, 1, 0,  0, 0, 32'h55, 2, 0);
    tbl[16] = mv(0, 0, 32'h0,  1, 0, 0,  1, 1, 32'h55, 3, 0);
    tbl[17] = mv(0, 0, 32'h0,  1, 0, 0,  1, 0, 32'h0,  3, 0);
    tbl[18] = mv(0, 1, 32'hB0, 0, 0, 0,  1, 0, 32'h0,  3, 0);
    tbl[19] = mv(0, 1, 32'hB1, 0, 0, 0,  1, 1, 32'hB0, 3, 0);
    tbl[20] = mv(0, 1, 32'hB2, 1, 0, 1,  0, 0, 32'hB0, 3, 0);
    tbl[21] = mv(0, 0, 32'h0,  1, 0, 0,  1, 0, 32'h0,  3, 1);
    tbl[22] = mv(0, 0, 32'h0,  1, 1, 1,  0, 0, 32'h0,  3, 1);
    tbl[23] = mv(0, 1, 32'hC0, 1, 0, 0,  1, 0, 32'h0,  3, 2);
    tbl[24] = mv(1, 1, 32'hC1, 1, 0, 0,  0, 0, 32'hC0, 3, 2);
    tbl[25] = mv(0, 0, 32'h0,  1, 0, 0,  1, 0, 32'h0,  0, 0);

    // Unchecked power-on reset so every register starts defined.
    for (int k = 0; k < 3; k++) drive(k, 1, 0, 32'h0, 0, 0, 0);
    to_next();

    // HOLD / skid stage: table-driven.
    for (int i = 0; i < 26; i++) begin
      drive(0, tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].o, tbl[i].s, tbl[i].c);
      to_neg();
      chk_port(0, $sformatf("row%0d", i), tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_od);
      chk($sformatf("row%0d stall_cnt", i), {112'd0, sc0}, 128'(tbl[i].e_sc));
      chk($sformatf("row%0d flush_cnt", i), {112'd0, fc0}, 128'(tbl[i].e_fc));
      to_next();
    end

    // BUBBLE stage: 0x77 drains in the first stall cycle, then a bubble.
    drive(1, 0, 1, 32'h77, 0, 0, 0); to_next();
    drive(1, 0, 1, 32'h78, 1, 1, 0); to_neg();
    chk_port(1, "bub c1", 0, 1, 32'h77);
    to_next();
    // Stall held 6 cycles in total: 2-bit counter reads 1,2,3,3,3,3.
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 1, 32'h79, 1, 1, 0); to_neg();
      chk_port(1, $sformatf("bub c%0d", i + 2), 0, 0, 32'h0);
      chk($sformatf("sat %0d", i), {126'd0, sc1}, (i < 2) ? 128'(i + 1) : 128'd3);
      to_next();
    end
    drive(1, 0, 0, 32'h0, 1, 0, 0); to_neg();
    chk("sat final", {126'd0, sc1}, 128'd3);
    to_next();
    drive(1, 1, 0, 32'h0, 1, 0, 0); to_next();
    drive(1, 0, 0, 32'h0, 1, 0, 0); to_neg();
    chk("sat reset", {126'd0, sc1}, 128'd0);
    to_next();

    // BUBBLE with skid full: retained while out_ready=0, then skid refills main.
    drive(1, 0, 1, 32'h90, 0, 0, 0); to_next();
    drive(1, 0, 1, 32'h91, 0, 0, 0); to_next();
    drive(1, 0, 1, 32'h92, 0, 1, 0); to_neg();
    chk_port(1, "bsk hold", 0, 1, 32'h90); to_next();
    drive(1, 0, 0, 32'h0, 1, 1, 0); to_neg();
    chk_port(1, "bsk out0", 0, 1, 32'h90); to_next();
    to_neg();
    chk_port(1, "bsk out1", 0, 1, 32'h91); to_next();
    to_neg();
    chk_port(1, "bsk empty", 0, 0, 32'h0); to_next();
    drive(1, 0, 0, 32'h0, 1, 0, 0); to_neg();
    chk_port(1, "bsk rel", 1, 0, 32'h0); to_next();

    // Single-entry stage: in_ready follows out_ready when full.
    drive(2, 0, 1, 32'hE0, 0, 0, 0); to_neg();
    chk_port(2, "s0 e1", 1, 0, 32'h0); to_next();
    drive(2, 0, 1, 32'hE1, 0, 0, 0); to_neg();
    chk_port(2, "s0 e2", 0, 1, 32'hE0); to_next();
    drive(2, 0, 1, 32'hE1, 1, 0, 0); to_neg();
    chk_port(2, "s0 e3", 1, 1, 32'hE0); to_next();
    drive(2, 0, 0, 32'h0, 1, 0, 0); to_neg();
    chk_port(2, "s0 e4", 1, 1, 32'hE1); to_next();
    to_neg();
    chk_port(2, "s0 e5", 1, 0, 32'h0); to_next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
